// File: rtl/sd_init_pkg.sv
// SD card SPI-mode init: shared constants, state/error enums and the
// command-frame builder.
package sd_init_pkg;

    localparam logic [5:0] IDX_CMD0   = 6'd0;
    localparam logic [5:0] IDX_CMD8   = 6'd8;
    localparam logic [5:0] IDX_CMD55  = 6'd55;
    localparam logic [5:0] IDX_ACMD41 = 6'd41;
    localparam logic [5:0] IDX_CMD58  = 6'd58;

    // crc7 fields; with the stop bit the last frame byte is 0x95 / 0x87
    localparam logic [6:0] CRC_CMD0 = 7'h4A;
    localparam logic [6:0] CRC_CMD8 = 7'h43;
    localparam logic [6:0] CRC_OFF  = 7'h00;

    localparam logic [31:0] ARG_NONE   = 32'h0000_0000;
    localparam logic [31:0] ARG_CMD8   = 32'h0000_01AA;
    localparam logic [31:0] ARG_ACMD41 = 32'h4000_0000;

    localparam logic [9:0] NB_R1 = 10'd1;
    localparam logic [9:0] NB_R7 = 10'd5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PWRUP,
        S_CMD0,
        S_CMD8,
        S_CMD55,
        S_ACMD41,
        S_CMD58,
        S_DONE,
        S_ERR
    } state_e;

    typedef enum logic [2:0] {
        T_IDLE,
        T_ISSUE,
        T_WACC,
        T_WEND,
        T_DONE
    } txn_e;

    typedef enum logic [2:0] {
        ERR_NONE,
        ERR_PWR,
        ERR_CMD0,
        ERR_CMD8,
        ERR_V1,
        ERR_ACMD41,
        ERR_CMD58,
        ERR_TMO
    } err_e;

    typedef logic [4:0][7:0] resp_t;

    function automatic logic [47:0] build_frame(
        input logic [5:0]  idx,
        input logic [31:0] arg,
        input logic [6:0]  crc7
    );
        return {2'b01, idx, arg, crc7, 1'b1};
    endfunction

endpackage

// File: rtl/sd_init_ctrl_if.sv
// Command/response link between the init sequencer and the SPI
// output engine.
interface sd_init_ctrl_if;

    logic [47:0] spi_cmd_data;
    logic        spi_cmd;
    logic [9:0]  spi_bytes_expected;
    logic        spi_busy;
    logic        spi_error;
    logic [7:0]  spi_response;
    logic        spi_avail;

    modport master (
        output spi_cmd_data,
        output spi_cmd,
        output spi_bytes_expected,
        input  spi_busy,
        input  spi_error,
        input  spi_response,
        input  spi_avail
    );

    modport slave (
        input  spi_cmd_data,
        input  spi_cmd,
        input  spi_bytes_expected,
        output spi_busy,
        output spi_error,
        output spi_response,
        output spi_avail
    );

endinterface

// File: rtl/sd_spi_txn.sv
// One SPI command transaction: issue, accept, end/timeout, capture of
// the first five response bytes and a one-cycle ok/fail status.
module sd_spi_txn
    import sd_init_pkg::*;
#(
    parameter int RESP_TMO = 4096
)(
    input  logic           clk,
    input  logic           res,
    input  logic           i_go,
    input  logic [47:0]    i_frame,
    input  logic [9:0]     i_nbytes,
    output logic           o_done,
    output logic           o_ok,
    output logic           o_tmo,
    output resp_t          o_resp,
    sd_init_ctrl_if.master spi
);

    localparam int TW = $clog2(RESP_TMO + 1);

    txn_e        r_ph;
    txn_e        w_ph_nxt;
    logic [47:0] r_frame;
    logic [9:0]  r_nbytes;
    logic        r_cmd;
    logic [9:0]  r_cnt;
    logic [TW-1:0] r_tcnt;
    logic        r_err;
    logic        r_to;
    resp_t       r_resp;
    logic        w_wait;
    logic        w_tlast;
    logic        w_to;

    assign w_wait  = (r_ph == T_WACC) || (r_ph == T_WEND);
    assign w_tlast = (r_tcnt == TW'(RESP_TMO - 1));

    always_ff @(posedge clk) begin
        if (res) r_ph <= T_IDLE;
        else     r_ph <= w_ph_nxt;
    end

    always_comb begin
        w_ph_nxt = r_ph;
        w_to     = 1'b0;
        unique case (r_ph)
            T_IDLE:  if (i_go) w_ph_nxt = T_ISSUE;
            T_ISSUE: if (!spi.spi_busy) w_ph_nxt = T_WACC;
            T_WACC: begin
                if (spi.spi_busy) begin
                    w_ph_nxt = T_WEND;
                end else if (w_tlast) begin
                    w_ph_nxt = T_DONE;
                    w_to     = 1'b1;
                end
            end
            T_WEND: begin
                if (!spi.spi_busy) begin
                    w_ph_nxt = T_DONE;
                end else if (w_tlast) begin
                    w_ph_nxt = T_DONE;
                    w_to     = 1'b1;
                end
            end
            T_DONE:  w_ph_nxt = T_IDLE;
            default: w_ph_nxt = T_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_frame  <= '0;
            r_nbytes <= '0;
            r_cmd    <= 1'b0;
            r_cnt    <= '0;
            r_tcnt   <= '0;
            r_err    <= 1'b0;
            r_to     <= 1'b0;
            r_resp   <= '0;
        end else begin
            r_cmd <= (r_ph == T_ISSUE) && !spi.spi_busy;
            if ((r_ph == T_IDLE) && i_go) begin
                r_frame  <= i_frame;
                r_nbytes <= i_nbytes;
            end
            if (r_ph == T_ISSUE) begin
                r_cnt  <= '0;
                r_tcnt <= '0;
                r_err  <= 1'b0;
                r_to   <= 1'b0;
                r_resp <= '0;
            end
            // bytes and errors still count on the cycle busy falls
            if (w_wait) begin
                r_tcnt <= r_tcnt + 1'b1;
                if (spi.spi_error) r_err <= 1'b1;
                if (w_to) r_to <= 1'b1;
                if (spi.spi_avail) begin
                    if (r_cnt < 10'd5)
                        r_resp[r_cnt[2:0]] <= spi.spi_response;
                    if (r_cnt != '1)
                        r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_done = (r_ph == T_DONE);
    assign o_ok   = !r_err && !r_to && (r_cnt >= r_nbytes);
    assign o_tmo  = r_to;
    assign o_resp = r_resp;

    assign spi.spi_cmd_data       = r_frame;
    assign spi.spi_cmd            = r_cmd;
    assign spi.spi_bytes_expected = r_nbytes;

endmodule

// File: rtl/sd_init_ctrl.sv
// SPI-mode SD init sequencer: CMD0, CMD8, CMD55/ACMD41 polling, CMD58,
// with per-command retries, then switches the SD clock to fast.
module sd_init_ctrl
    import sd_init_pkg::*;
#(
    parameter int PWRUP_CYC   = 1000,
    parameter int RESP_TMO    = 4096,
    parameter int CMD_RETRIES = 3,
    parameter int ACMD41_MAX  = 1000
)(
    input  logic           clk,
    input  logic           res,
    input  logic           start,
    output logic           init_done,
    output logic           init_error,
    output logic [2:0]     err_code,
    output logic           card_hc,
    output logic           speed,
    sd_init_ctrl_if.master spi
);

    localparam int PW = $clog2(PWRUP_CYC + 1);
    localparam int RW = $clog2(CMD_RETRIES + 1);
    localparam int AW = $clog2(ACMD41_MAX + 1);

    state_e        r_st, w_st;
    logic [PW-1:0] r_pw, w_pw;
    logic [RW-1:0] r_retry, w_retry;
    logic [AW-1:0] r_round, w_round;
    logic          r_done, w_done;
    logic          r_err, w_err;
    err_e          r_code, w_code, w_fcode;
    logic          r_hc, w_hc;
    logic          r_speed, w_speed;
    logic          w_fail;

    logic          w_go;
    logic [47:0]   w_frame;
    logic [9:0]    w_nb;
    logic          w_tdone;
    logic          w_tok;
    logic          w_tto;
    resp_t         w_resp;
    logic [7:0]    w_r1;
    logic          w_r7_ok;
    logic          w_unused;

    assign w_r1     = w_resp[0];
    assign w_r7_ok  = (w_resp[3][3:0] == 4'h1) && (w_resp[4] == 8'hAA);
    assign w_unused = ^{w_resp[3][7:4], w_resp[2], w_resp[1][5:0]};

    sd_spi_txn #(
        .RESP_TMO (RESP_TMO)
    ) u_txn (
        .clk      (clk),
        .res      (res),
        .i_go     (w_go),
        .i_frame  (w_frame),
        .i_nbytes (w_nb),
        .o_done   (w_tdone),
        .o_ok     (w_tok),
        .o_tmo    (w_tto),
        .o_resp   (w_resp),
        .spi      (spi)
    );

    always_comb begin
        w_go    = 1'b1;
        w_nb    = NB_R1;
        w_frame = build_frame(IDX_CMD0, ARG_NONE, CRC_CMD0);
        unique case (r_st)
            S_CMD0: begin
                w_frame = build_frame(IDX_CMD0, ARG_NONE, CRC_CMD0);
            end
            S_CMD8: begin
                w_frame = build_frame(IDX_CMD8, ARG_CMD8, CRC_CMD8);
                w_nb    = NB_R7;
            end
            S_CMD55: begin
                w_frame = build_frame(IDX_CMD55, ARG_NONE, CRC_OFF);
            end
            S_ACMD41: begin
                w_frame = build_frame(IDX_ACMD41, ARG_ACMD41, CRC_OFF);
            end
            S_CMD58: begin
                w_frame = build_frame(IDX_CMD58, ARG_NONE, CRC_OFF);
                w_nb    = NB_R7;
            end
            default: w_go = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_st    <= S_IDLE;
            r_pw    <= '0;
            r_retry <= '0;
            r_round <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_code  <= ERR_NONE;
            r_hc    <= 1'b0;
            r_speed <= 1'b0;
        end else begin
            r_st    <= w_st;
            r_pw    <= w_pw;
            r_retry <= w_retry;
            r_round <= w_round;
            r_done  <= w_done;
            r_err   <= w_err;
            r_code  <= w_code;
            r_hc    <= w_hc;
            r_speed <= w_speed;
        end
    end

    always_comb begin
        w_st    = r_st;
        w_pw    = r_pw;
        w_retry = r_retry;
        w_round = r_round;
        w_done  = r_done;
        w_err   = r_err;
        w_code  = r_code;
        w_hc    = r_hc;
        w_speed = r_speed;
        w_fail  = 1'b0;
        w_fcode = ERR_NONE;
        unique case (r_st)
            S_IDLE: begin
                if (start) begin
                    w_st = S_PWRUP;
                    w_pw = '0;
                end
            end
            S_PWRUP: begin
                if (r_pw == PW'(PWRUP_CYC - 1)) begin
                    w_st    = S_CMD0;
                    w_retry = '0;
                end else begin
                    w_pw = r_pw + 1'b1;
                end
            end
            S_CMD0: if (w_tdone) begin
                w_fcode = ERR_CMD0;
                if (w_tok && (w_r1 == 8'h01)) begin
                    w_st    = S_CMD8;
                    w_retry = '0;
                end else begin
                    w_fail = 1'b1;
                end
            end
            S_CMD8: if (w_tdone) begin
                w_fcode = ERR_CMD8;
                if (!w_tok) begin
                    w_fail = 1'b1;
                end else if ((w_r1 == 8'h01) && w_r7_ok) begin
                    w_st    = S_CMD55;
                    w_retry = '0;
                    w_round = '0;
                end else begin
                    // illegal-command bit: a v1 card, which we do not support
                    w_st   = S_ERR;
                    w_err  = 1'b1;
                    w_code = w_r1[2] ? ERR_V1 : ERR_CMD8;
                end
            end
            S_CMD55: if (w_tdone) begin
                w_fcode = ERR_ACMD41;
                if (w_tok && (w_r1[7:1] == 7'h00)) begin
                    w_st    = S_ACMD41;
                    w_retry = '0;
                end else begin
                    w_fail = 1'b1;
                end
            end
            S_ACMD41: if (w_tdone) begin
                w_fcode = ERR_ACMD41;
                if (w_tok && (w_r1 == 8'h00)) begin
                    w_st    = S_CMD58;
                    w_retry = '0;
                end else if (w_tok && (w_r1 == 8'h01)) begin
                    w_round = r_round + 1'b1;
                    w_retry = '0;
                    if (w_round == AW'(ACMD41_MAX)) begin
                        w_st   = S_ERR;
                        w_err  = 1'b1;
                        w_code = ERR_ACMD41;
                    end else begin
                        w_st = S_CMD55;
                    end
                end else begin
                    w_fail = 1'b1;
                end
            end
            S_CMD58: if (w_tdone) begin
                w_fcode = ERR_CMD58;
                if (w_tok && (w_r1 == 8'h00)) begin
                    if (w_resp[1][7]) begin
                        w_st    = S_DONE;
                        w_hc    = w_resp[1][6];
                        w_done  = 1'b1;
                        w_speed = 1'b1;
                    end else begin
                        w_st   = S_ERR;
                        w_err  = 1'b1;
                        w_code = ERR_CMD58;
                    end
                end else begin
                    w_fail = 1'b1;
                end
            end
            S_DONE, S_ERR: begin
                if (start) begin
                    w_st    = S_PWRUP;
                    w_pw    = '0;
                    w_done  = 1'b0;
                    w_err   = 1'b0;
                    w_code  = ERR_NONE;
                    w_speed = 1'b0;
                end
            end
            default: w_st = S_IDLE;
        endcase
        if (w_fail) begin
            if (w_tto) w_fcode = ERR_TMO;
            if (r_retry >= RW'(CMD_RETRIES - 1)) begin
                w_st   = S_ERR;
                w_err  = 1'b1;
                w_code = w_fcode;
            end else begin
                w_retry = r_retry + 1'b1;
            end
        end
    end

    assign init_done  = r_done;
    assign init_error = r_err;
    assign err_code   = r_code;
    assign card_hc    = r_hc;
    assign speed      = r_speed;

endmodule

// File: tb/tb_sd_init_ctrl.sv
// Bench for sd_init_ctrl: scripted SPI-engine model with a frame
// scoreboard, covering success, retry, error and restart paths.
module tb_sd_init_ctrl;
    import sd_init_pkg::*;

    localparam logic [47:0] F0  = 48'h40_0000_0000_95;
    localparam logic [47:0] F8  = 48'h48_0000_01AA_87;
    localparam logic [47:0] F55 = 48'h77_0000_0000_01;
    localparam logic [47:0] F41 = 48'h69_4000_0000_01;
    localparam logic [47:0] F58 = 48'h7A_0000_0000_01;
    localparam logic [39:0] R7_OK = 40'h01_0000_01AA;

    typedef struct {
        logic [47:0] fr;
        logic [9:0]  nb;
    } exp_t;

    typedef struct {
        bit          err;
        bit          nob;
        int          n;
        logic [39:0] b;
    } scr_t;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       start = 1'b0;
    logic       init_done;
    logic       init_error;
    logic [2:0] err_code;
    logic       card_hc;
    logic       speed;

    exp_t exp_q[$];
    scr_t scr_q[$];
    scr_t m_e;
    bit   m_act = 1'b0;
    int   m_k = 0;
    int   ncmd[64];
    int   total = 0;
    int   bad = 0;

    sd_init_ctrl_if u_if();

    sd_init_ctrl #(
        .PWRUP_CYC   (10),
        .RESP_TMO    (64),
        .CMD_RETRIES (3),
        .ACMD41_MAX  (4)
    ) u_dut (
        .clk        (clk),
        .res        (res),
        .start      (start),
        .init_done  (init_done),
        .init_error (init_error),
        .err_code   (err_code),
        .card_hc    (card_hc),
        .speed      (speed),
        .spi        (u_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic add(input logic [47:0] fr, input logic [9:0] nb,
                       input bit err, input bit nob, input int n,
                       input logic [39:0] b);
        exp_t e;
        scr_t s;
        e.fr = fr;
        e.nb = nb;
        exp_q.push_back(e);
        s.err = err;
        s.nob = nob;
        s.n = n;
        s.b = b;
        scr_q.push_back(s);
    endtask

    task automatic ok1(input logic [47:0] fr, input logic [7:0] r1);
        add(fr, 10'd1, 1'b0, 1'b0, 1, {r1, 32'h0});
    endtask

    task automatic ok5(input logic [47:0] fr, input logic [39:0] b);
        add(fr, 10'd5, 1'b0, 1'b0, 5, b);
    endtask

    task automatic clr();
        foreach (ncmd[i]) ncmd[i] = 0;
        exp_q.delete();
        scr_q.delete();
    endtask

    task automatic take_cmd();
        exp_t e;
        ncmd[u_if.spi_cmd_data[45:40]]++;
        if (exp_q.size() == 0) begin
            chk("unexp_frame", u_if.spi_cmd_data, '0);
        end else begin
            e = exp_q.pop_front();
            chk("frame", u_if.spi_cmd_data, e.fr);
            chk("nbytes", u_if.spi_bytes_expected, e.nb);
        end
        if (scr_q.size() == 0) begin
            m_e.nob = 1'b1;
        end else begin
            m_e = scr_q.pop_front();
        end
        if (!m_e.nob) begin
            m_act = 1'b1;
            m_k = 0;
            u_if.spi_busy = 1'b1;
        end
    endtask

    // engine model: last byte arrives together with busy falling
    always @(negedge clk) begin
        u_if.spi_avail = 1'b0;
        u_if.spi_error = 1'b0;
        if (res) begin
            u_if.spi_busy = 1'b0;
            u_if.spi_response = 8'h00;
            m_act = 1'b0;
        end else if (m_act) begin
            if (m_k < m_e.n) begin
                u_if.spi_response = m_e.b[39 - 8*m_k -: 8];
                u_if.spi_avail = 1'b1;
                m_k++;
            end
            if (m_k >= m_e.n) begin
                u_if.spi_busy = 1'b0;
                u_if.spi_error = m_e.err;
                m_act = 1'b0;
            end
        end else if (u_if.spi_cmd) begin
            take_cmd();
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (init_done || init_error) begin
                hit = 1'b1;
                break;
            end
        end
        chk({tag, "_end"}, hit, 1);
        chk({tag, "_expq"}, exp_q.size(), 0);
        chk({tag, "_scrq"}, scr_q.size(), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_done"}, init_done, 0);
        chk({tag, "_err"}, init_error, 0);
        chk({tag, "_code"}, err_code, 0);
        chk({tag, "_hc"}, card_hc, 0);
        chk({tag, "_speed"}, speed, 0);
        chk({tag, "_data"}, u_if.spi_cmd_data, 0);
        chk({tag, "_cmd"}, u_if.spi_cmd, 0);
        chk({tag, "_nb"}, u_if.spi_bytes_expected, 0);
    endtask

    initial begin
        bit hit;
        repeat (3) @(negedge clk);
        chk_zero("rst");
        res = 1'b0;

        // SDHC card, two busy ACMD41 rounds
        clr();
        ok1(F0, 8'h01);
        ok5(F8, R7_OK);
        ok1(F55, 8'h01); ok1(F41, 8'h01);
        ok1(F55, 8'h01); ok1(F41, 8'h01);
        ok1(F55, 8'h01); ok1(F41, 8'h00);
        ok5(F58, 40'h00_C0FF_8000);
        pulse_start();
        wait_end("t1");
        chk("t1_done", init_done, 1);
        chk("t1_err", init_error, 0);
        chk("t1_hc", card_hc, 1);
        chk("t1_speed", speed, 1);
        chk("t1_n41", ncmd[41], 3);

        // CMD0 engine errors twice, then succeeds
        clr();
        add(F0, 10'd1, 1'b1, 1'b0, 0, '0);
        add(F0, 10'd1, 1'b1, 1'b0, 0, '0);
        ok1(F0, 8'h01);
        ok5(F8, R7_OK);
        ok1(F55, 8'h01); ok1(F41, 8'h00);
        ok5(F58, 40'h00_C0FF_8000);
        pulse_start();
        chk("t2_done_drop", init_done, 0);
        chk("t2_speed_drop", speed, 0);
        wait_end("t2");
        chk("t2_done", init_done, 1);
        chk("t2_n0", ncmd[0], 3);
        chk("t2_code", err_code, 0);

        // v1 card
        clr();
        ok1(F0, 8'h01);
        ok5(F8, 40'h05_0000_0000);
        pulse_start();
        wait_end("t3");
        chk("t3_err", init_error, 1);
        chk("t3_code", err_code, ERR_V1);
        chk("t3_speed", speed, 0);
        chk("t3_done", init_done, 0);
        chk("t3_n55", ncmd[55], 0);

        // card stays idle through every ACMD41 round
        clr();
        ok1(F0, 8'h01);
        ok5(F8, R7_OK);
        repeat (4) begin
            ok1(F55, 8'h01);
            ok1(F41, 8'h01);
        end
        pulse_start();
        wait_end("t4");
        chk("t4_err", init_error, 1);
        chk("t4_code", err_code, ERR_ACMD41);
        chk("t4_n55", ncmd[55], 4);
        chk("t4_n41", ncmd[41], 4);

        // engine never accepts: CMD0 times out on every attempt
        clr();
        repeat (3) add(F0, 10'd1, 1'b0, 1'b1, 0, '0);
        pulse_start();
        wait_end("t5");
        chk("t5_err", init_error, 1);
        chk("t5_code", err_code, ERR_TMO);
        chk("t5_n0", ncmd[0], 3);

        // reset while CMD8 is outstanding
        clr();
        ok1(F0, 8'h01);
        add(F8, 10'd5, 1'b0, 1'b1, 0, '0);
        pulse_start();
        hit = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (ncmd[8] != 0) begin
                hit = 1'b1;
                break;
            end
        end
        chk("t5_cmd8_seen", hit, 1);
        repeat (5) @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        chk_zero("t5_rst");
        res = 1'b0;
        chk("t5_expq", exp_q.size(), 0);

        // standard-capacity card, then restart from DONE
        clr();
        ok1(F0, 8'h01);
        ok5(F8, R7_OK);
        ok1(F55, 8'h01); ok1(F41, 8'h00);
        ok5(F58, 40'h00_80FF_8000);
        pulse_start();
        wait_end("t6");
        chk("t6_done", init_done, 1);
        chk("t6_err", init_error, 0);
        chk("t6_hc", card_hc, 0);
        chk("t6_speed", speed, 1);
        pulse_start();
        chk("t6_done_drop", init_done, 0);
        chk("t6_speed_drop", speed, 0);
        res = 1'b1;
        repeat (2) @(negedge clk);
        res = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
